// File: rtl/jtbubl_sdram_bridge.sv
// Bridges ROM-slot reads (two 16-bit words) and download byte writes onto a single
// 16-bit SDRAM command port, inserting periodic refresh cycles.
module jtbubl_sdram_bridge #(
    parameter int REFRESH_PERIOD = 384,
    parameter int AW             = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic          sdram_req,
    input  logic [AW-1:0] sdram_addr,
    output logic          sdram_ack,
    output logic          data_rdy,
    output logic [31:0]   data_read,
    input  logic          refresh_en,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [1:0]    prog_mask,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_dsn,
    output logic          mem_rfsh,
    input  logic          mem_done,
    input  logic [15:0]   mem_dout
);

    // state | meaning
    // IDLE  | arbitrate refresh / download write / ROM read
    // RD_LO | read low word at latched address
    // RD_HI | read high word at latched address + 1
    // WR    | download write of one byte pair
    // RFSH  | refresh cycle
    // DONE  | data_read presented with data_rdy
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR, RFSH, DONE} state_t;

    localparam int            CW        = $clog2(REFRESH_PERIOD + 1);
    localparam logic [CW-1:0] RFSH_LAST = CW'(REFRESH_PERIOD - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] rfsh_cnt;
    logic          rfsh_pend;
    logic          rfsh_clr;
    logic [AW-1:0] op_addr, op_addr_nxt;
    logic [7:0]    wr_data, wr_data_nxt;
    logic [1:0]    wr_mask, wr_mask_nxt;
    logic [15:0]   lo_word, lo_word_nxt;
    logic          sdram_ack_nxt, data_rdy_nxt;
    logic [31:0]   data_read_nxt;
    logic          mem_req_nxt, mem_we_nxt, mem_rfsh_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [15:0]   mem_din_nxt;
    logic [1:0]    mem_dsn_nxt;

    // A wrap coinciding with refresh completion keeps the request pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            rfsh_cnt  <= '0;
            rfsh_pend <= 1'b0;
        end else if (rfsh_cnt == RFSH_LAST) begin
            rfsh_cnt  <= '0;
            rfsh_pend <= 1'b1;
        end else begin
            rfsh_cnt <= rfsh_cnt + CW'(1);
            if (rfsh_clr) rfsh_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_addr   <= '0;
            wr_data   <= '0;
            wr_mask   <= 2'b11;
            lo_word   <= '0;
            sdram_ack <= 1'b0;
            data_rdy  <= 1'b0;
            data_read <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_rfsh  <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_dsn   <= 2'b11;
        end else begin
            state     <= state_nxt;
            op_addr   <= op_addr_nxt;
            wr_data   <= wr_data_nxt;
            wr_mask   <= wr_mask_nxt;
            lo_word   <= lo_word_nxt;
            sdram_ack <= sdram_ack_nxt;
            data_rdy  <= data_rdy_nxt;
            data_read <= data_read_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_rfsh  <= mem_rfsh_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_din   <= mem_din_nxt;
            mem_dsn   <= mem_dsn_nxt;
        end
    end

    // Each command state raises mem_req only while it is low, which guarantees the
    // idle cycle between the low and high read words.
    always_comb begin
        state_nxt     = state;
        op_addr_nxt   = op_addr;
        wr_data_nxt   = wr_data;
        wr_mask_nxt   = wr_mask;
        lo_word_nxt   = lo_word;
        sdram_ack_nxt = 1'b0;
        data_rdy_nxt  = 1'b0;
        data_read_nxt = data_read;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_rfsh_nxt  = mem_rfsh;
        mem_addr_nxt  = mem_addr;
        mem_din_nxt   = mem_din;
        mem_dsn_nxt   = mem_dsn;
        rfsh_clr      = 1'b0;

        case (state)
            IDLE: begin
                if (rfsh_pend && (refresh_en || downloading)) begin
                    state_nxt = RFSH;
                end else if (downloading && prog_we) begin
                    state_nxt   = WR;
                    op_addr_nxt = prog_addr;
                    wr_data_nxt = prog_data;
                    wr_mask_nxt = prog_mask;
                end else if (sdram_req && !downloading) begin
                    state_nxt     = RD_LO;
                    op_addr_nxt   = sdram_addr;
                    sdram_ack_nxt = 1'b1;
                end
            end
            RD_LO: begin
                if (!mem_req) begin
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_rfsh_nxt = 1'b0;
                    mem_addr_nxt = op_addr;
                    mem_dsn_nxt  = 2'b00;
                end else if (mem_done) begin
                    mem_req_nxt = 1'b0;
                    lo_word_nxt = mem_dout;
                    state_nxt   = RD_HI;
                end
            end
            RD_HI: begin
                if (!mem_req) begin
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_rfsh_nxt = 1'b0;
                    mem_addr_nxt = op_addr + AW'(1);
                    mem_dsn_nxt  = 2'b00;
                end else if (mem_done) begin
                    mem_req_nxt   = 1'b0;
                    data_read_nxt = {mem_dout, lo_word};
                    data_rdy_nxt  = 1'b1;
                    state_nxt     = DONE;
                end
            end
            WR: begin
                if (!mem_req) begin
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b1;
                    mem_rfsh_nxt = 1'b0;
                    mem_addr_nxt = op_addr;
                    mem_din_nxt  = {wr_data, wr_data};
                    mem_dsn_nxt  = wr_mask;
                end else if (mem_done) begin
                    mem_req_nxt   = 1'b0;
                    sdram_ack_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            RFSH: begin
                if (!mem_req) begin
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_rfsh_nxt = 1'b1;
                end else if (mem_done) begin
                    mem_req_nxt = 1'b0;
                    rfsh_clr    = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_jtbubl_sdram_bridge.sv
// Scoreboard bench for jtbubl_sdram_bridge: directed reads, writes, refresh and reset
// scenarios against a one-cycle-latency memory model.
module tb_jtbubl_sdram_bridge;
    localparam int AW = 22;
    localparam int RP = 16;
    localparam logic [1:0] K_RD = 2'd0;
    localparam logic [1:0] K_WR = 2'd1;
    localparam logic [1:0] K_RF = 2'd2;

    logic          clk = 1'b0;
    logic          rst, downloading, sdram_req, refresh_en, prog_we, mem_done;
    logic [AW-1:0] sdram_addr, prog_addr, mem_addr;
    logic [7:0]    prog_data;
    logic [1:0]    prog_mask, mem_dsn;
    logic          sdram_ack, data_rdy, mem_req, mem_we, mem_rfsh;
    logic [31:0]   data_read;
    logic [15:0]   mem_din, mem_dout;

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    dsn;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_data[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ack_pending = 0;
    int          acks_seen = 0;
    int          rfsh_seen = 0;
    bit          track_rfsh = 1'b0;
    logic [15:0] mem_img[int];
    int          mcnt = 0;

    always #5 clk = ~clk;

    jtbubl_sdram_bridge #(.REFRESH_PERIOD(RP), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .downloading(downloading),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .data_read  (data_read),
        .refresh_en (refresh_en),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_mask  (prog_mask),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dsn    (mem_dsn),
        .mem_rfsh   (mem_rfsh),
        .mem_done   (mem_done),
        .mem_dout   (mem_dout)
    );

    // Reference refresh counter, used to time a request onto the pending-refresh edge.
    initial begin : refresh_model
        forever begin
            @(posedge clk);
            if (rst === 1'b1) mcnt = 0;
            else mcnt = (mcnt == RP - 1) ? 0 : mcnt + 1;
        end
    end

    // Memory answers one cycle after it first sees mem_req.
    initial begin : mem_model
        int age;
        age      = 0;
        mem_done = 1'b0;
        mem_dout = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_done) begin
                mem_done = 1'b0;
                age      = 0;
            end else if (mem_req === 1'b1) begin
                if (age >= 1) begin
                    mem_done = 1'b1;
                    mem_dout = mem_img.exists(int'(mem_addr)) ? mem_img[int'(mem_addr)] : 16'hDEAD;
                    age      = 0;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    initial begin : cmd_monitor
        cmd_t           e;
        logic [AW+19:0] cur, prev_snap;
        logic           prev_req, prev_done, prev_rst, ok;
        prev_req  = 1'b0;
        prev_done = 1'b0;
        prev_rst  = 1'b0;
        prev_snap = '0;
        forever begin
            @(negedge clk);
            cur = {mem_we, mem_rfsh, mem_addr, mem_din, mem_dsn};
            if (prev_req && prev_done) begin
                n_cmp++;
                if (mem_req !== 1'b0) begin
                    n_err++;
                    $display("FAIL req_after_done: mem_req=%b required 0", mem_req);
                end
            end
            if (prev_req && !prev_done && !prev_rst) begin
                n_cmp++;
                if (mem_req !== 1'b1 || cur !== prev_snap) begin
                    n_err++;
                    $display("FAIL cmd_stable: mem_req=%b fields=%h required 1/%h", mem_req, cur, prev_snap);
                end
            end
            if (mem_req === 1'b1 && !prev_req) begin
                if (mem_rfsh === 1'b1) rfsh_seen++;
                if (mem_rfsh !== 1'b1 || track_rfsh) begin
                    n_cmp++;
                    if (exp_cmd.size() == 0) begin
                        n_err++;
                        $display("FAIL mem_cmd: unexpected command we=%b rfsh=%b addr=%h", mem_we, mem_rfsh, mem_addr);
                    end else begin
                        e  = exp_cmd.pop_front();
                        ok = (mem_we === (e.kind == K_WR)) && (mem_rfsh === (e.kind == K_RF));
                        if (e.kind != K_RF) ok = ok && (mem_addr === e.addr) && (mem_dsn === e.dsn);
                        if (e.kind == K_WR) ok = ok && (mem_din === e.din);
                        if (!ok) begin
                            n_err++;
                            $display("FAIL mem_cmd: got we=%b rfsh=%b addr=%h din=%h dsn=%b, required kind=%0d addr=%h din=%h dsn=%b",
                                     mem_we, mem_rfsh, mem_addr, mem_din, mem_dsn, e.kind, e.addr, e.din, e.dsn);
                        end
                    end
                end
            end
            prev_req  = (mem_req === 1'b1);
            prev_done = (mem_done === 1'b1);
            prev_rst  = (rst === 1'b1);
            prev_snap = cur;
        end
    end

    initial begin : out_monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (sdram_ack === 1'b1) begin
                acks_seen++;
                n_cmp++;
                if (ack_pending == 0) begin
                    n_err++;
                    $display("FAIL sdram_ack: got unexpected pulse, required none");
                end else begin
                    ack_pending--;
                end
            end
            if (data_rdy === 1'b1) begin
                n_cmp++;
                if (exp_data.size() == 0) begin
                    n_err++;
                    $display("FAIL data_rdy: got unexpected pulse data_read=%h, required none", data_read);
                end else begin
                    e = exp_data.pop_front();
                    if (data_read !== e) begin
                        n_err++;
                        $display("FAIL data_read: got %h required %h", data_read, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] k, input logic [AW-1:0] a,
                                input logic [15:0] d, input logic [1:0] m);
        cmd_t c;
        c.kind = k;
        c.addr = a;
        c.din  = d;
        c.dsn  = m;
        return c;
    endfunction

    task automatic do_read(input logic [AW-1:0] a_lo, input logic [AW-1:0] a_hi,
                           input logic [31:0] exp, output int lat);
        exp_cmd.push_back(mk(K_RD, a_lo, 16'h0000, 2'b00));
        exp_cmd.push_back(mk(K_RD, a_hi, 16'h0000, 2'b00));
        exp_data.push_back(exp);
        ack_pending++;
        sdram_addr = a_lo;
        sdram_req  = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (data_rdy !== 1'b1 && lat < 200) begin
            if (sdram_ack === 1'b1) sdram_req = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        sdram_req = 1'b0;
        if (lat >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL read_timeout: got no data_rdy for addr %h, required within 200 cycles", a_lo);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] m,
                            input logic [15:0] exp_din);
        int n;
        exp_cmd.push_back(mk(K_WR, a, exp_din, m));
        ack_pending++;
        downloading = 1'b1;
        prog_we     = 1'b1;
        prog_addr   = a;
        prog_data   = d;
        prog_mask   = m;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (sdram_ack !== 1'b1 && n < 200);
        prog_we     = 1'b0;
        downloading = 1'b0;
        if (n >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL write_timeout: got no sdram_ack for addr %h, required within 200 cycles", a);
        end
    endtask

    initial begin : stim
        int lat, n, a0, r0;
        rst         = 1'b1;
        downloading = 1'b0;
        sdram_req   = 1'b0;
        sdram_addr  = '0;
        refresh_en  = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_mask   = 2'b11;
        mem_img[32'h00100]  = 16'h1234;
        mem_img[32'h00101]  = 16'hABCD;
        mem_img[32'h3FFFFF] = 16'hBEEF;
        mem_img[32'h00000]  = 16'hCAFE;
        mem_img[32'h00500]  = 16'h0F0F;
        mem_img[32'h00501]  = 16'hF0F0;
        mem_img[32'h00300]  = 16'h1111;
        mem_img[32'h00301]  = 16'h2222;
        mem_img[32'h00040]  = 16'h4444;
        mem_img[32'h00041]  = 16'h8888;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_rfsh", 32'(mem_rfsh), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_din", 32'(mem_din), 32'h0);
        chk("rst_mem_dsn", 32'(mem_dsn), 32'h3);
        chk("rst_sdram_ack", 32'(sdram_ack), 32'h0);
        chk("rst_data_rdy", 32'(data_rdy), 32'h0);
        chk("rst_data_read", data_read, 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // basic read, latency and hold of data_read
        do_read(22'h000100, 22'h000101, 32'hABCD1234, lat);
        chk("read_latency", 32'(lat), 32'd6);
        repeat (3) @(posedge clk);
        #1;
        chk("data_read_hold", data_read, 32'hABCD1234);

        // high-word address wraps to zero
        do_read(22'h3FFFFF, 22'h000000, 32'hCAFEBEEF, lat);
        repeat (3) @(posedge clk);
        #1;

        // download write (a pending refresh may run first)
        do_write(22'h000200, 8'h5A, 2'b10, 16'h5A5A);
        repeat (3) @(posedge clk);
        #1;

        // read held off while downloading
        downloading = 1'b1;
        sdram_addr  = 22'h000500;
        sdram_req   = 1'b1;
        a0 = acks_seen;
        repeat (20) @(posedge clk);
        #1;
        chk("no_ack_while_downloading", 32'(acks_seen), 32'(a0));
        downloading = 1'b0;
        do_read(22'h000500, 22'h000501, 32'hF0F00F0F, lat);
        repeat (3) @(posedge clk);
        #1;

        // reset during the high-word read
        exp_cmd.push_back(mk(K_RD, 22'h000300, 16'h0000, 2'b00));
        exp_cmd.push_back(mk(K_RD, 22'h000301, 16'h0000, 2'b00));
        ack_pending++;
        sdram_addr = 22'h000300;
        sdram_req  = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (sdram_ack === 1'b1) sdram_req = 1'b0;
        end while (!(mem_req === 1'b1 && mem_addr === 22'h000301) && n < 100);
        sdram_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mid_data_rdy", 32'(data_rdy), 32'h0);
        chk("rst_mid_data_read", data_read, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        do_read(22'h000300, 22'h000301, 32'h22221111, lat);
        repeat (3) @(posedge clk);
        #1;

        // refresh wins against a read arriving as the refresh becomes pending
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        refresh_en = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (mcnt != 0 && n < 64);
        track_rfsh = 1'b1;
        exp_cmd.push_back(mk(K_RF, 22'h000000, 16'h0000, 2'b00));
        r0 = rfsh_seen;
        do_read(22'h000040, 22'h000041, 32'h88884444, lat);
        refresh_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        track_rfsh = 1'b0;
        chk("rfsh_before_read_count", 32'(rfsh_seen - r0), 32'd1);

        // no refresh issued while disabled and not downloading
        r0 = rfsh_seen;
        repeat (40) @(posedge clk);
        #1;
        chk("no_rfsh_when_disabled", 32'(rfsh_seen), 32'(r0));

        repeat (5) @(posedge clk);
        #1;
        chk("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        chk("data_queue_empty", 32'(exp_data.size()), 32'd0);
        chk("acks_outstanding", 32'(ack_pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jtbubl_sdram_bridge.md
JTBUBL_SDRAM_BRIDGE -- requirements
Module: jtbubl_sdram_bridge

Interface
REQ-001 Parameter: REFRESH_PERIOD, 384, clocks between refresh requests.
REQ-002 Parameter: AW, 22, word-address width on both sides.
REQ-003 clk  in  1  system clock; the block uses this single clock.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 downloading  in  1  ROM load in progress; selects the write path, blocks reads.
REQ-006 sdram_req  in  1  read request from the ROM slot arbiter; held until sdram_ack.
REQ-007 sdram_addr  in  AW  16-bit word address of the read.
REQ-008 sdram_ack  out  1  one-cycle pulse: read accepted, or prog write completed.
REQ-009 data_rdy  out  1  one-cycle pulse: data_read valid.
REQ-010 data_read  out  32  read result {word addr+1, word addr}.
REQ-011 refresh_en  in  1  refresh allowed now.
REQ-012 prog_we / prog_addr / prog_data / prog_mask  in  1/AW/8/2  download write; mask is active-low per byte.
REQ-013 mem_req / mem_we / mem_addr / mem_din / mem_dsn  out  1/1/AW/16/2  memory port command; dsn is active-low.
REQ-014 mem_rfsh  out  1  refresh command; qualified by mem_req.
REQ-015 mem_done  in  1  memory cycle finished; mem_dout valid this cycle.
REQ-016 mem_dout  in  16  memory read word.

Function
REQ-017 FSM states: IDLE, RD_LO, RD_HI, WR, RFSH, DONE.
REQ-018 Refresh counter: counts 0..REFRESH_PERIOD-1 and wraps. At wrap it sets rfsh_pend. rfsh_pend clears when the RFSH cycle completes. A second wrap while already pending does not queue another refresh.
REQ-019 Arbitration in IDLE, in priority order:
- RFSH if rfsh_pend and (refresh_en or downloading).
- WR if downloading and prog_we.
- RD_LO if sdram_req and not downloading.
- Otherwise stay in IDLE.
REQ-020 Read acceptance: on IDLE->RD_LO, latch sdram_addr and pulse sdram_ack on the next cycle, exactly once per request.
REQ-021 RD_LO: mem_req=1, mem_we=0, mem_dsn=00, mem_addr=latched addr. On mem_done, capture mem_dout into data_read[15:0] and go to RD_HI.
REQ-022 RD_HI: mem_addr = latched addr + 1, modulo 2^AW (all-ones wraps to 0). On mem_done, capture data_read[31:16] and go to DONE.
REQ-023 DONE: data_rdy=1 for one cycle, then IDLE. data_read holds its value until the next RD_HI capture.
REQ-024 WR: mem_req=1, mem_we=1, mem_addr=prog_addr (latched), mem_din={prog_data,prog_data}, mem_dsn=prog_mask. On mem_done, pulse sdram_ack for one cycle and go to IDLE.
REQ-025 RFSH: mem_req=1, mem_rfsh=1, mem_we=0. On mem_done, go to IDLE.
REQ-026 Memory handshake:
- mem_req and all command fields stay stable from assertion until the cycle mem_done=1.
- mem_req is 0 in the cycle after mem_done.
- At least one cycle of mem_req=0 separates consecutive commands.
REQ-027 Minimum latency with mem_done returned one cycle after mem_req: data_rdy 6 cycles after sdram_req is sampled.
REQ-028 An accepted operation always completes, even if downloading or refresh_en changes mid-operation.
REQ-029 sdram_req raised while downloading=1 is held off, with no ack, until downloading=0.
REQ-030 mem_done outside RD_LO, RD_HI, WR or RFSH is ignored.

Reset
REQ-031 While rst=1, registers take these values on the next clk edge: FSM=IDLE, refresh counter=0, rfsh_pend=0, all mem_* outputs=0 except mem_dsn=11, sdram_ack=0, data_rdy=0, data_read=0.
REQ-032 Reset mid-operation abandons the operation: no ack and no data_rdy follow it.

Verification
REQ-033 Read, addr 0x00100, mem returns 0x1234 then 0xABCD, done 1 cycle after req -> exactly one sdram_ack; data_read=0xABCD1234 with one data_rdy pulse; mem_addr 0x00100 then 0x00101.
REQ-034 Read at addr 0x3FFFFF -> second mem_addr=0x000000.
REQ-035 downloading=1, prog_we with addr 0x00200, data 0x5A, mask 10 -> mem_we=1, mem_din=0x5A5A, mem_dsn=10; sdram_ack pulses after mem_done.
REQ-036 REFRESH_PERIOD=16, refresh_en=1, and sdram_req arriving the same cycle rfsh_pend sets -> RFSH first, then the read; with refresh_en=0, no mem_rfsh appears.
REQ-037 sdram_req asserted while downloading=1 for 20 cycles -> no ack during that time; read serviced after downloading falls.
REQ-038 rst pulsed during RD_HI -> mem_req=0 next cycle, no data_rdy, data_read=0; a following read completes normally.
